id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Pipeline register and operand-select stage between instruction decode and the 32-bit ALU. It captures decoded operands and control each cycle and inserts bubbles on flush or load-use hazards. It resolves operand A/B, with forwarding from the MEM and WB stages, so the ALU receives final operands and its 4-bit ALUControl directly. It also drives the stall request back to PC and the IF/ID register.

## Interface
- No parameters. Data width is fixed at 32 and register index width at 5, both taken from the shared package.
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- ID_Valid  in  1  decode slot holds a real instruction
- ID_ReadData1, ID_ReadData2, ID_SignExtImm  in  32 each  register-file reads and the extended immediate
- ID_Rs, ID_Rt, ID_Rd  in  5 each  register indices
- ID_UsesRt  in  1  instruction reads Rt as a source
- ID_ALUControl  in  4  ALU operation code: 0000 add, 0001 sub, 0010 mul, 0011 and, 0100 or
- ID_ALUSrc, ID_RegDst, ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg  in  1 each  decoded controls
- Flush  in  1  branch/jump squash of the decode slot
- HoldIn  in  1  downstream freeze
- MEM_RegWrite  in  1, MEM_Rd  in  5, MEM_ALUResult  in  32  EX/MEM forwarding source
- WB_RegWrite  in  1, WB_Rd  in  5, WB_Data  in  32  MEM/WB forwarding source
- StallOut  out  1  hold PC and IF/ID
- ALU_A, ALU_B  out  32  final ALU operands
- ALUControl  out  4  registered operation code
- EX_StoreData  out  32  forwarded Rt value for stores
- EX_DestReg  out  5  selected destination register
- EX_Valid, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg  out  1 each  registered controls

## Operation
- Register update priority, evaluated each rising edge: Reset, then Flush, then HoldIn, then LoadUse, then normal load.
  - Flush: load a bubble.
  - HoldIn: retain all contents.
  - LoadUse: load a bubble.
  - Normal: capture every ID_* input.
- Bubble: EX_Valid=0, all write, memory and RegWrite controls 0, ALUControl=0000, data fields 0.
- LoadUse = EX_Valid & EX_MemRead & (EX_Rt≠0) & (EX_Rt==ID_Rs | (ID_UsesRt & EX_Rt==ID_Rt)) & ID_Valid.
- StallOut = (LoadUse | HoldIn) & ~Flush. StallOut is combinational.
- Forwarding for operand A:
  - Use MEM_ALUResult if MEM_RegWrite & MEM_Rd≠0 & MEM_Rd==EX_Rs.
  - Else use WB_Data if WB_RegWrite & WB_Rd≠0 & WB_Rd==EX_Rs.
  - Else use EX_ReadData1.
  - When MEM and WB both match, MEM wins.
- Forwarding for Rt follows the same rule and produces EX_StoreData.
- ALU_B = EX_ALUSrc ? EX_SignExtImm : EX_StoreData.
- EX_DestReg = EX_RegDst ? EX_Rd : EX_Rt.
- Register $0 is never forwarded.

## Timing
- Latency is 1 cycle: ID inputs at edge N appear on registered outputs after edge N.
- ALU_A, ALU_B and EX_StoreData are combinational from the registers and the MEM/WB ports, within the same cycle.
- A load-use hazard produces exactly one bubble. The dependent instruction enters EX one cycle late, and the WB forward then supplies the load data.
- Flush and LoadUse in the same cycle: a bubble is loaded and StallOut=0.
- Flush and HoldIn in the same cycle: a bubble is loaded, because Flush has priority.
- Reset (async assert, deassert on any edge): all registered outputs 0, EX_Valid=0, StallOut=0 while in reset.
- Reset asserted mid-stall discards the held instruction.

## Configuration
- ID_EX_FORWARD_EN defined: forwarding as described above.
- ID_EX_FORWARD_EN undefined:
  - No forwarding paths. ALU_A=EX_ReadData1 and EX_StoreData=EX_ReadData2.
  - MEM_ALUResult and WB_Data are ignored.
  - LoadUse widens to any RAW hazard: ID source matches either of the following, with the index ≠0:
    - EX_DestReg, when EX_Valid & EX_RegWrite.
    - MEM_Rd, when MEM_RegWrite.
  - The register file is write-before-read, so WB needs no check.

## Structure
- Shared package (pipeline package) holds:
  - DATA_W=32 and REG_W=5.
  - ALUControl encodings: ALU_ADD, ALU_SUB, ALU_MUL, ALU_AND, ALU_OR.
  - The bubble control constant.
- One sub-module, fwd_mux: 3-way priority select (MEM, WB, reg) for one operand. It is instantiated twice, for Rs and Rt, and is compiled only under ID_EX_FORWARD_EN.

## Test plan
- Reset low with all ID inputs nonzero -> all outputs 0, EX_Valid=0. Release and load add (ReadData1=5, ReadData2=7, ALUSrc=0) -> next cycle ALU_A=5, ALU_B=7, ALUControl=0000.
- EX holds Rs=8 and MEM_RegWrite=1, MEM_Rd=8, MEM_ALUResult=0x1234, with WB_Rd=8, WB_Data=0x9999 -> ALU_A=0x1234 (MEM priority). Repeat with Rs=0 -> ALU_A=EX_ReadData1.
- lw $9 in EX, then ID add with Rs=9 -> StallOut=1 for one cycle and one bubble (EX_Valid=0). The next cycle has WB_Rd=9, WB_Data=42 -> ALU_A=42.
- Flush=1 together with a load-use hazard -> bubble loaded, StallOut=0.
- HoldIn=1 for 3 cycles while ID changes -> outputs unchanged, StallOut=1. Release -> current ID contents captured.
- With ID_EX_FORWARD_EN undefined: add writing $3 in EX, then sub reading $3 -> two stall cycles, then ALU_A equals the register-file value.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline definitions for the ID/EX stage: widths, ALU operation
// codes, the registered EX slot layout and the bubble constant.
package id_ex_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_MUL = 4'b0010,
    ALU_AND = 4'b0011,
    ALU_OR  = 4'b0100
  } alu_ctl_e;

  // Everything the ID/EX register holds for one instruction.
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] readData1;
    logic [DATA_W-1:0] readData2;
    logic [DATA_W-1:0] signExtImm;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [3:0]        aluControl;
    logic              aluSrc;
    logic              regDst;
    logic              regWrite;
    logic              memRead;
    logic              memWrite;
    logic              memToReg;
  } id_ex_t;

  // A bubble is an all-zero slot: invalid, no writes, ALU add, zero data.
  localparam id_ex_t BUBBLE = '0;

  // True when a nonzero producer index feeds one of the decode sources.
  function automatic logic srcMatch(input logic [REG_W-1:0] idx,
                                    input logic [REG_W-1:0] rs,
                                    input logic [REG_W-1:0] rt,
                                    input logic             usesRt);
    return (idx != '0) && ((idx == rs) || (usesRt && (idx == rt)));
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Three-way priority operand select: EX/MEM result, then MEM/WB data, then
// the register-file value. Register $0 is never forwarded.
// Only present when ID_EX_FORWARD_EN is defined.
`ifdef ID_EX_FORWARD_EN
module fwd_mux
  import id_ex_stage_pkg::*;
(
  input  logic              memRegWrite_i,
  input  logic [REG_W-1:0]  memRd_i,
  input  logic [DATA_W-1:0] memData_i,
  input  logic              wbRegWrite_i,
  input  logic [REG_W-1:0]  wbRd_i,
  input  logic [DATA_W-1:0] wbData_i,
  input  logic [REG_W-1:0]  srcReg_i,
  input  logic [DATA_W-1:0] regData_i,
  output logic [DATA_W-1:0] operand_o
);

  // The younger producer (MEM) wins when both stages write the same register.
  always_comb begin
    operand_o = regData_i;
    if (memRegWrite_i && (memRd_i != '0) && (memRd_i == srcReg_i)) begin
      operand_o = memData_i;
    end else if (wbRegWrite_i && (wbRd_i != '0) && (wbRd_i == srcReg_i)) begin
      operand_o = wbData_i;
    end
  end

endmodule
`endif

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand selection and hazard detection.
// Captures decoded operands/control, inserts bubbles on flush or hazard,
// and hands the ALU its final operands and operation code.
// Build option: ID_EX_FORWARD_EN enables MEM/WB forwarding; without it the
// stage stalls on every read-after-write hazard instead.
// Reset is asynchronous and active-low.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ID_Valid,
  input  logic [DATA_W-1:0] ID_ReadData1,
  input  logic [DATA_W-1:0] ID_ReadData2,
  input  logic [DATA_W-1:0] ID_SignExtImm,
  input  logic [REG_W-1:0]  ID_Rs,
  input  logic [REG_W-1:0]  ID_Rt,
  input  logic [REG_W-1:0]  ID_Rd,
  input  logic              ID_UsesRt,
  input  logic [3:0]        ID_ALUControl,
  input  logic              ID_ALUSrc,
  input  logic              ID_RegDst,
  input  logic              ID_RegWrite,
  input  logic              ID_MemRead,
  input  logic              ID_MemWrite,
  input  logic              ID_MemToReg,
  input  logic              Flush,
  input  logic              HoldIn,
  input  logic              MEM_RegWrite,
  input  logic [REG_W-1:0]  MEM_Rd,
  input  logic [DATA_W-1:0] MEM_ALUResult,
  input  logic              WB_RegWrite,
  input  logic [REG_W-1:0]  WB_Rd,
  input  logic [DATA_W-1:0] WB_Data,
  output logic              StallOut,
  output logic [DATA_W-1:0] ALU_A,
  output logic [DATA_W-1:0] ALU_B,
  output logic [3:0]        ALUControl,
  output logic [DATA_W-1:0] EX_StoreData,
  output logic [REG_W-1:0]  EX_DestReg,
  output logic              EX_Valid,
  output logic              EX_RegWrite,
  output logic              EX_MemRead,
  output logic              EX_MemWrite,
  output logic              EX_MemToReg
);

  id_ex_t            exSlot_q;
  id_ex_t            exSlot_d;
  id_ex_t            idSlot;
  logic              loadUse;
  logic [REG_W-1:0]  exDestReg;
  logic [DATA_W-1:0] operandA;
  logic [DATA_W-1:0] storeData;

  assign idSlot = '{
    valid:      ID_Valid,
    readData1:  ID_ReadData1,
    readData2:  ID_ReadData2,
    signExtImm: ID_SignExtImm,
    rs:         ID_Rs,
    rt:         ID_Rt,
    rd:         ID_Rd,
    aluControl: ID_ALUControl,
    aluSrc:     ID_ALUSrc,
    regDst:     ID_RegDst,
    regWrite:   ID_RegWrite,
    memRead:    ID_MemRead,
    memWrite:   ID_MemWrite,
    memToReg:   ID_MemToReg
  };

  assign exDestReg = exSlot_q.regDst ? exSlot_q.rd : exSlot_q.rt;

`ifdef ID_EX_FORWARD_EN
  // With forwarding only a load in EX can't supply its result in time.
  assign loadUse = ID_Valid & exSlot_q.valid & exSlot_q.memRead &
                   srcMatch(exSlot_q.rt, ID_Rs, ID_Rt, ID_UsesRt);

  fwd_mux uFwdRs (
    .memRegWrite_i (MEM_RegWrite),
    .memRd_i       (MEM_Rd),
    .memData_i     (MEM_ALUResult),
    .wbRegWrite_i  (WB_RegWrite),
    .wbRd_i        (WB_Rd),
    .wbData_i      (WB_Data),
    .srcReg_i      (exSlot_q.rs),
    .regData_i     (exSlot_q.readData1),
    .operand_o     (operandA)
  );

  fwd_mux uFwdRt (
    .memRegWrite_i (MEM_RegWrite),
    .memRd_i       (MEM_Rd),
    .memData_i     (MEM_ALUResult),
    .wbRegWrite_i  (WB_RegWrite),
    .wbRd_i        (WB_Rd),
    .wbData_i      (WB_Data),
    .srcReg_i      (exSlot_q.rt),
    .regData_i     (exSlot_q.readData2),
    .operand_o     (storeData)
  );
`else
  logic unusedFwdPorts;

  // Without forwarding, any pending write in EX or MEM to a source must
  // drain; WB is covered because the register file writes before reading.
  assign loadUse = ID_Valid &
                   ((exSlot_q.valid & exSlot_q.regWrite &
                     srcMatch(exDestReg, ID_Rs, ID_Rt, ID_UsesRt)) |
                    (MEM_RegWrite & srcMatch(MEM_Rd, ID_Rs, ID_Rt, ID_UsesRt)));

  assign operandA       = exSlot_q.readData1;
  assign storeData      = exSlot_q.readData2;
  assign unusedFwdPorts = ^{MEM_ALUResult, WB_RegWrite, WB_Rd, WB_Data};
`endif

  // Stall is suppressed by flush (the stalled slot is being squashed) and
  // forced low while reset is held.
  assign StallOut = Reset & (loadUse | HoldIn) & ~Flush;

  // Next slot by priority: flush bubble, hold, hazard bubble, normal capture.
  always_comb begin
    exSlot_d = exSlot_q;
    if (Flush) begin
      exSlot_d = BUBBLE;
    end else if (HoldIn) begin
      exSlot_d = exSlot_q;
    end else if (loadUse) begin
      exSlot_d = BUBBLE;
    end else begin
      exSlot_d = idSlot;
    end
  end

  // The pipeline register itself; reset discards whatever was held.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      exSlot_q <= BUBBLE;
    end else begin
      exSlot_q <= exSlot_d;
    end
  end

  assign ALU_A        = operandA;
  assign EX_StoreData = storeData;
  assign ALU_B        = exSlot_q.aluSrc ? exSlot_q.signExtImm : storeData;
  assign ALUControl   = exSlot_q.aluControl;
  assign EX_DestReg   = exDestReg;
  assign EX_Valid     = exSlot_q.valid;
  assign EX_RegWrite  = exSlot_q.regWrite;
  assign EX_MemRead   = exSlot_q.memRead;
  assign EX_MemWrite  = exSlot_q.memWrite;
  assign EX_MemToReg  = exSlot_q.memToReg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed table, hand-written hazard
// sequences and random traffic, all compared against a behavioural model.
// Follows ID_EX_FORWARD_EN the same way the design does.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        ID_Valid, ID_UsesRt, ID_ALUSrc, ID_RegDst, ID_RegWrite;
  logic        ID_MemRead, ID_MemWrite, ID_MemToReg, Flush, HoldIn;
  logic [31:0] ID_ReadData1, ID_ReadData2, ID_SignExtImm;
  logic [4:0]  ID_Rs, ID_Rt, ID_Rd;
  logic [3:0]  ID_ALUControl;
  logic        MEM_RegWrite, WB_RegWrite;
  logic [4:0]  MEM_Rd, WB_Rd;
  logic [31:0] MEM_ALUResult, WB_Data;
  logic        StallOut, EX_Valid, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg;
  logic [31:0] ALU_A, ALU_B, EX_StoreData;
  logic [3:0]  ALUControl;
  logic [4:0]  EX_DestReg;

  id_ex_stage dut (
    .Clk(Clk), .Reset(Reset), .ID_Valid(ID_Valid),
    .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2),
    .ID_SignExtImm(ID_SignExtImm), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
    .ID_UsesRt(ID_UsesRt), .ID_ALUControl(ID_ALUControl), .ID_ALUSrc(ID_ALUSrc),
    .ID_RegDst(ID_RegDst), .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead),
    .ID_MemWrite(ID_MemWrite), .ID_MemToReg(ID_MemToReg), .Flush(Flush),
    .HoldIn(HoldIn), .MEM_RegWrite(MEM_RegWrite), .MEM_Rd(MEM_Rd),
    .MEM_ALUResult(MEM_ALUResult), .WB_RegWrite(WB_RegWrite), .WB_Rd(WB_Rd),
    .WB_Data(WB_Data), .StallOut(StallOut), .ALU_A(ALU_A), .ALU_B(ALU_B),
    .ALUControl(ALUControl), .EX_StoreData(EX_StoreData), .EX_DestReg(EX_DestReg),
    .EX_Valid(EX_Valid), .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
    .EX_MemWrite(EX_MemWrite), .EX_MemToReg(EX_MemToReg)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        rstN;
    logic        valid;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    logic        usesRt;
    logic [3:0]  ctl;
    logic        aluSrc, regDst, regWrite, memRead, memWrite, memToReg;
    logic        flush, hold;
    logic        memRW;
    logic [4:0]  memRd;
    logic [31:0] memRes;
    logic        wbRW;
    logic [4:0]  wbRd;
    logic [31:0] wbData;
  } inVec_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    logic [3:0]  ctl;
    logic        aluSrc, regDst, regWrite, memRead, memWrite, memToReg;
  } slot_t;

  typedef struct {
    inVec_t      stim;
    logic        expValid;
    logic [31:0] expA, expB;
    logic [3:0]  expCtl;
    logic        expStall;
  } vecRec_t;

  slot_t       model = '0;
  int          errors = 0;
  int          checks = 0;
  logic        smpValid, smpStall;
  logic [31:0] smpA, smpB;
  logic [3:0]  smpCtl;

  function automatic inVec_t idle();
    inVec_t v = '0;
    v.rstN = 1'b1;
    return v;
  endfunction

  function automatic inVec_t instr(input logic [4:0] rs, input logic [4:0] rt,
                                   input logic [4:0] rd, input logic usesRt,
                                   input logic [31:0] rd1, input logic [31:0] rd2,
                                   input logic [31:0] imm, input logic [3:0] ctl,
                                   input logic aluSrc, input logic regDst,
                                   input logic regWrite, input logic memRead);
    inVec_t v = idle();
    v.valid = 1'b1; v.rs = rs; v.rt = rt; v.rd = rd; v.usesRt = usesRt;
    v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.ctl = ctl; v.aluSrc = aluSrc;
    v.regDst = regDst; v.regWrite = regWrite; v.memRead = memRead;
    v.memToReg = memRead;
    return v;
  endfunction

  function automatic slot_t slotFrom(input inVec_t v);
    slot_t s;
    s.valid = v.valid; s.rd1 = v.rd1; s.rd2 = v.rd2; s.imm = v.imm;
    s.rs = v.rs; s.rt = v.rt; s.rd = v.rd; s.ctl = v.ctl; s.aluSrc = v.aluSrc;
    s.regDst = v.regDst; s.regWrite = v.regWrite; s.memRead = v.memRead;
    s.memWrite = v.memWrite; s.memToReg = v.memToReg;
    return s;
  endfunction

  // Does the decoding instruction read register idx (never $0)?
  function automatic logic readsReg(input logic [4:0] idx, input inVec_t v);
    return (idx != 5'd0) && (idx == v.rs || (v.usesRt && idx == v.rt));
  endfunction

  function automatic logic refHazard(input slot_t s, input inVec_t v);
    if (!v.valid) return 1'b0;
`ifdef ID_EX_FORWARD_EN
    return s.valid && s.memRead && readsReg(s.rt, v);
`else
    return (s.valid && s.regWrite && readsReg(s.regDst ? s.rd : s.rt, v)) ||
           (v.memRW && readsReg(v.memRd, v));
`endif
  endfunction

`ifdef ID_EX_FORWARD_EN
  function automatic logic [31:0] refOperand(input logic [4:0] src,
                                             input logic [31:0] regVal,
                                             input inVec_t v);
    if (src == 5'd0) return regVal;
    if (v.memRW && v.memRd == src) return v.memRes;
    if (v.wbRW && v.wbRd == src) return v.wbData;
    return regVal;
  endfunction
`endif

  task automatic checkField(input string name, input logic [31:0] got,
                            input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic checkOutput(input string tag, input inVec_t v, input logic haz);
    logic [31:0] eA, eStore, eB;
    logic        eStall;
`ifdef ID_EX_FORWARD_EN
    eA     = refOperand(model.rs, model.rd1, v);
    eStore = refOperand(model.rt, model.rd2, v);
`else
    eA     = model.rd1;
    eStore = model.rd2;
`endif
    eB     = model.aluSrc ? model.imm : eStore;
    eStall = v.rstN && (haz || v.hold) && !v.flush;
    checkField({tag, ".EX_Valid"},     32'(EX_Valid),     32'(model.valid));
    checkField({tag, ".ALUControl"},   32'(ALUControl),   32'(model.ctl));
    checkField({tag, ".ALU_A"},        ALU_A,             eA);
    checkField({tag, ".ALU_B"},        ALU_B,             eB);
    checkField({tag, ".EX_StoreData"}, EX_StoreData,      eStore);
    checkField({tag, ".EX_DestReg"},   32'(EX_DestReg),   32'(model.regDst ? model.rd : model.rt));
    checkField({tag, ".EX_RegWrite"},  32'(EX_RegWrite),  32'(model.regWrite));
    checkField({tag, ".EX_MemRead"},   32'(EX_MemRead),   32'(model.memRead));
    checkField({tag, ".EX_MemWrite"},  32'(EX_MemWrite),  32'(model.memWrite));
    checkField({tag, ".EX_MemToReg"},  32'(EX_MemToReg),  32'(model.memToReg));
    checkField({tag, ".StallOut"},     32'(StallOut),     32'(eStall));
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model.
  task automatic applyStimulus(input inVec_t v, input string tag);
    slot_t nxt;
    logic  haz;
    @(negedge Clk);
    Reset = v.rstN; ID_Valid = v.valid; ID_ReadData1 = v.rd1;
    ID_ReadData2 = v.rd2; ID_SignExtImm = v.imm; ID_Rs = v.rs; ID_Rt = v.rt;
    ID_Rd = v.rd; ID_UsesRt = v.usesRt; ID_ALUControl = v.ctl;
    ID_ALUSrc = v.aluSrc; ID_RegDst = v.regDst; ID_RegWrite = v.regWrite;
    ID_MemRead = v.memRead; ID_MemWrite = v.memWrite; ID_MemToReg = v.memToReg;
    Flush = v.flush; HoldIn = v.hold; MEM_RegWrite = v.memRW; MEM_Rd = v.memRd;
    MEM_ALUResult = v.memRes; WB_RegWrite = v.wbRW; WB_Rd = v.wbRd;
    WB_Data = v.wbData;
    #1;
    if (!v.rstN) model = '0;
    smpValid = EX_Valid; smpStall = StallOut; smpA = ALU_A; smpB = ALU_B;
    smpCtl = ALUControl;
    haz = refHazard(model, v);
    checkOutput(tag, v, haz);
    if (!v.rstN || v.flush) nxt = '0;
    else if (v.hold)        nxt = model;
    else if (haz)           nxt = '0;
    else                    nxt = slotFrom(v);
    @(posedge Clk);
    model = nxt;
  endtask

  initial begin
    vecRec_t tbl[5];
    inVec_t  v, lw, addv, x, y;

    // Directed vectors: inputs for the cycle and what EX shows during it.
    tbl[0].stim = instr(5'd1, 5'd2, 5'd3, 1'b1, 32'd5, 32'd7, 32'd0, ALU_ADD, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[0].expValid = 1'b0; tbl[0].expA = 32'd0; tbl[0].expB = 32'd0;
    tbl[0].expCtl = 4'd0; tbl[0].expStall = 1'b0;
    tbl[1].stim = instr(5'd8, 5'd0, 5'd4, 1'b0, 32'h11, 32'h22, 32'h40, ALU_SUB, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[1].expValid = 1'b1; tbl[1].expA = 32'd5; tbl[1].expB = 32'd7;
    tbl[1].expCtl = 4'd0; tbl[1].expStall = 1'b0;
    tbl[2].stim = idle();
    tbl[2].stim.memRW = 1'b1; tbl[2].stim.memRd = 5'd8; tbl[2].stim.memRes = 32'h1234;
    tbl[2].stim.wbRW = 1'b1; tbl[2].stim.wbRd = 5'd8; tbl[2].stim.wbData = 32'h9999;
`ifdef ID_EX_FORWARD_EN
    tbl[2].expA = 32'h1234;
`else
    tbl[2].expA = 32'h11;
`endif
    tbl[2].expValid = 1'b1; tbl[2].expB = 32'h40; tbl[2].expCtl = 4'd1;
    tbl[2].expStall = 1'b0;
    tbl[3].stim = instr(5'd0, 5'd0, 5'd5, 1'b0, 32'h77, 32'd0, 32'd1, ALU_OR, 1'b1, 1'b1, 1'b1, 1'b0);
    tbl[3].stim.memRW = 1'b1; tbl[3].stim.memRd = 5'd8; tbl[3].stim.memRes = 32'h1234;
    tbl[3].stim.wbRW = 1'b1; tbl[3].stim.wbRd = 5'd8; tbl[3].stim.wbData = 32'h9999;
    tbl[3].expValid = 1'b0; tbl[3].expA = 32'd0; tbl[3].expB = 32'd0;
    tbl[3].expCtl = 4'd0; tbl[3].expStall = 1'b0;
    tbl[4].stim = idle();
    tbl[4].stim.memRW = 1'b1; tbl[4].stim.memRd = 5'd0; tbl[4].stim.memRes = 32'h1234;
    tbl[4].stim.wbRW = 1'b1; tbl[4].stim.wbRd = 5'd0; tbl[4].stim.wbData = 32'h9999;
    tbl[4].expValid = 1'b1; tbl[4].expA = 32'h77; tbl[4].expB = 32'd1;
    tbl[4].expCtl = 4'd4; tbl[4].expStall = 1'b0;

    // Reset with every input busy, including a hold request.
    v = instr(5'd1, 5'd2, 5'd3, 1'b1, 32'hFFFF_FFFF, 32'h1357, 32'h2468, ALU_OR, 1'b1, 1'b1, 1'b1, 1'b1);
    v.rstN = 1'b0; v.hold = 1'b1; v.memWrite = 1'b1; v.memRW = 1'b1; v.memRd = 5'd1;
    v.memRes = 32'hABCD; v.wbRW = 1'b1; v.wbRd = 5'd2; v.wbData = 32'h5A5A;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(v, $sformatf("rst%0d", i));
      checkField("rst.valid", 32'(smpValid), 32'd0);
      checkField("rst.stall", 32'(smpStall), 32'd0);
      checkField("rst.A", smpA, 32'd0);
    end

    for (int i = 0; i < 5; i++) begin
      applyStimulus(tbl[i].stim, $sformatf("tbl%0d", i));
      checkField($sformatf("tbl%0d.valid", i), 32'(smpValid), 32'(tbl[i].expValid));
      checkField($sformatf("tbl%0d.A", i), smpA, tbl[i].expA);
      checkField($sformatf("tbl%0d.B", i), smpB, tbl[i].expB);
      checkField($sformatf("tbl%0d.ctl", i), 32'(smpCtl), 32'(tbl[i].expCtl));
      checkField($sformatf("tbl%0d.stall", i), 32'(smpStall), 32'(tbl[i].expStall));
    end

    // Load-use: lw $9 then add reading $9.
    lw   = instr(5'd1, 5'd9, 5'd0, 1'b0, 32'h100, 32'd0, 32'd4, ALU_ADD, 1'b1, 1'b0, 1'b1, 1'b1);
    addv = instr(5'd9, 5'd2, 5'd10, 1'b1, 32'hDEAD, 32'd3, 32'd0, ALU_ADD, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(idle(), "lu0");
    applyStimulus(lw, "lu1");
    applyStimulus(addv, "lu2");
    checkField("lu2.stall", 32'(smpStall), 32'd1);
    checkField("lu2.valid", 32'(smpValid), 32'd1);
    v = addv; v.memRW = 1'b1; v.memRd = 5'd9; v.memRes = 32'h104;
    applyStimulus(v, "lu3");
    checkField("lu3.valid", 32'(smpValid), 32'd0);
`ifdef ID_EX_FORWARD_EN
    checkField("lu3.stall", 32'(smpStall), 32'd0);
    v = idle(); v.wbRW = 1'b1; v.wbRd = 5'd9; v.wbData = 32'd42;
    applyStimulus(v, "lu4");
    checkField("lu4.valid", 32'(smpValid), 32'd1);
    checkField("lu4.A", smpA, 32'd42);
`else
    checkField("lu3.stall", 32'(smpStall), 32'd1);
    v = addv; v.rd1 = 32'd42; v.wbRW = 1'b1; v.wbRd = 5'd9; v.wbData = 32'd42;
    applyStimulus(v, "lu4");
    checkField("lu4.stall", 32'(smpStall), 32'd0);
    checkField("lu4.valid", 32'(smpValid), 32'd0);
    applyStimulus(idle(), "lu5");
    checkField("lu5.valid", 32'(smpValid), 32'd1);
    checkField("lu5.A", smpA, 32'd42);
`endif

    // Flush together with a load-use hazard.
    applyStimulus(idle(), "fl0");
    applyStimulus(lw, "fl1");
    v = addv; v.flush = 1'b1;
    applyStimulus(v, "fl2");
    checkField("fl2.stall", 32'(smpStall), 32'd0);
    applyStimulus(idle(), "fl3");
    checkField("fl3.valid", 32'(smpValid), 32'd0);

    // Downstream hold for three cycles while decode keeps changing.
    x = instr(5'd4, 5'd5, 5'd6, 1'b1, 32'hAAAA, 32'hBBBB, 32'd0, ALU_AND, 1'b0, 1'b1, 1'b0, 1'b0);
    y = instr(5'd2, 5'd3, 5'd8, 1'b0, 32'h5555, 32'h6666, 32'h10, ALU_OR, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(x, "h0");
    for (int k = 0; k < 3; k++) begin
      v = instr(5'(k + 1), 5'(k + 2), 5'd7, 1'b1, $urandom, $urandom, $urandom, ALU_MUL, 1'b0, 1'b1, 1'b1, 1'b0);
      v.hold = 1'b1;
      applyStimulus(v, $sformatf("h%0d", k + 1));
      checkField("hold.stall", 32'(smpStall), 32'd1);
      checkField("hold.A", smpA, 32'hAAAA);
      checkField("hold.ctl", 32'(smpCtl), 32'd3);
    end
    applyStimulus(y, "h4");
    checkField("h4.stall", 32'(smpStall), 32'd0);
    checkField("h4.A", smpA, 32'hAAAA);
    applyStimulus(idle(), "h5");
    checkField("h5.A", smpA, 32'h5555);
    checkField("h5.B", smpB, 32'h10);
    checkField("h5.ctl", 32'(smpCtl), 32'd4);

    // Flush beats hold.
    applyStimulus(x, "fh0");
    v = y; v.flush = 1'b1; v.hold = 1'b1;
    applyStimulus(v, "fh1");
    checkField("fh1.stall", 32'(smpStall), 32'd0);
    applyStimulus(idle(), "fh2");
    checkField("fh2.valid", 32'(smpValid), 32'd0);

    // Reset arriving mid-stall throws the held instruction away.
    applyStimulus(idle(), "rs0");
    applyStimulus(lw, "rs1");
    applyStimulus(addv, "rs2");
    checkField("rs2.stall", 32'(smpStall), 32'd1);
    v = addv; v.rstN = 1'b0;
    applyStimulus(v, "rs3");
    checkField("rs3.stall", 32'(smpStall), 32'd0);
    checkField("rs3.valid", 32'(smpValid), 32'd0);
    applyStimulus(idle(), "rs4");
    checkField("rs4.valid", 32'(smpValid), 32'd0);

    // Random traffic on a small register set to provoke hazards often.
    for (int n = 0; n < 400; n++) begin
      v = idle();
      v.rstN     = ($urandom_range(0, 63) != 0);
      v.valid    = 1'($urandom_range(0, 1));
      v.rd1      = $urandom; v.rd2 = $urandom; v.imm = $urandom;
      v.rs       = 5'($urandom_range(0, 3));
      v.rt       = 5'($urandom_range(0, 3));
      v.rd       = 5'($urandom_range(0, 3));
      v.usesRt   = 1'($urandom_range(0, 1));
      v.ctl      = 4'($urandom_range(0, 4));
      v.aluSrc   = 1'($urandom_range(0, 1));
      v.regDst   = 1'($urandom_range(0, 1));
      v.regWrite = 1'($urandom_range(0, 1));
      v.memRead  = 1'($urandom_range(0, 1));
      v.memWrite = 1'($urandom_range(0, 1));
      v.memToReg = 1'($urandom_range(0, 1));
      v.flush    = ($urandom_range(0, 7) == 0);
      v.hold     = ($urandom_range(0, 7) == 0);
      v.memRW    = 1'($urandom_range(0, 1));
      v.memRd    = 5'($urandom_range(0, 3));
      v.memRes   = $urandom;
      v.wbRW     = 1'($urandom_range(0, 1));
      v.wbRd     = 5'($urandom_range(0, 3));
      v.wbData   = $urandom;
      applyStimulus(v, $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
